imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Parametrised program loader between an external byte stream and the CPU instruction memory. It takes a byte stream with valid/ready handshake and packs bytes into words, little- or big-endian. It writes the words to consecutive instruction-memory addresses from 0, then raises `cpu_enable` so `control` starts fetching. It is the synthesizable successor to preloading memory directly from the bench.

## Interface
- `WORD_W`, 32, instruction/memory word width; must be a multiple of `BYTE_W`
- `BYTE_W`, 8, stream symbol width
- `DEPTH`, 1024, instruction memory depth in words
- `ADDR_W`, 10, memory address width; `2**ADDR_W >= DEPTH`
- `BIG_ENDIAN`, 0, 0: first byte of a word goes to bits [BYTE_W-1:0]; 1: first byte goes to the MSBs
- Derived: `NB = WORD_W/BYTE_W` bytes per word.
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  load request, sampled only in IDLE
- `len`  in  ADDR_W+1  number of words to load, sampled with `start`
- `abort`  in  1  cancel load or run; has priority over all other inputs
- `s_data`  in  BYTE_W  stream byte
- `s_valid`  in  1  `s_data` valid
- `s_ready`  out  1  loader accepts a byte this cycle
- `mem_wen`  out  1  instruction-memory write strobe, one cycle per word
- `mem_addr`  out  ADDR_W  write address
- `mem_wdata`  out  WORD_W  packed word
- `cpu_enable`  out  1  CPU run enable (drives `control.enable`)
- `busy`  out  1  high in COLLECT or WRITE
- `err`  out  1  sticky: `len > DEPTH` requested; cleared by the next accepted `start` or by reset

## Operation
- The state machine has four states: IDLE, COLLECT, WRITE, RUN.
- Reset (async) puts the block in IDLE and clears all outputs, `mem_addr`, `mem_wdata`, the byte counter and the word counter to 0.
- In IDLE with `start=1`:
  - `len > DEPTH`: set `err`; stay in IDLE.
  - `len == 0`: clear `err`; go to RUN.
  - otherwise: clear `err`, latch `len`, clear the counters, go to COLLECT.
- COLLECT:
  - `s_ready=1`.
  - On `s_valid & s_ready`, place `s_data` into the byte lane selected by the byte counter and `BIG_ENDIAN`:
    - little-endian: lane k = bits [k*BYTE_W +: BYTE_W]
    - big-endian: lane k = bits [(NB-1-k)*BYTE_W +: BYTE_W]
  - Increment the byte counter.
  - On the NB-th accepted byte, go to WRITE.
- WRITE (exactly one cycle):
  - `s_ready=0`, `mem_wen=1`.
  - `mem_addr` = word counter; `mem_wdata` = packed word.
  - Next state: if word counter+1 == latched `len`, go to RUN; else increment the word counter, clear the byte counter, return to COLLECT.
- RUN: `cpu_enable=1` and `s_ready=0`. The block stays in RUN until `abort` or reset. `start` is ignored.
- `abort` in any state: go to IDLE next cycle.
  - Clears the byte and word counters and `cpu_enable`.
  - A partially packed word is discarded.
  - Words already written are not retracted.
- `start` outside IDLE is ignored.
- Bytes offered outside COLLECT are not consumed (`s_ready=0`).

## Timing
- All outputs are registered and decoded from the state register, except `s_ready`. `s_ready` = (state == COLLECT) & !`abort`.
- One word costs at least NB+1 cycles: NB accept cycles plus one WRITE cycle.
- `s_valid` gaps stretch COLLECT with no loss of data.
- `mem_addr` and `mem_wdata` are stable during the `mem_wen` cycle. Memory captures on the same rising edge that ends WRITE.
- `cpu_enable` rises in the cycle directly after the last WRITE cycle. With `len == 0`, it rises in the cycle after `start`.
- `busy` is high from the cycle after an accepted `start` through the last WRITE cycle.
- `err` is set in the cycle after a rejected `start`.
- Addresses do not wrap: `len ≤ DEPTH` guarantees the largest address written is DEPTH-1.
- An asynchronous `rst` mid-word drops the partial word and drops `cpu_enable` immediately.

## Test plan
- Default params, `len=6`, stream the 24 bytes of a 6-instruction program (including `hlt` at word 5) with `s_valid` held high. Required:
  - 6 `mem_wen` pulses at addresses 0..5.
  - Word 0 = {b3,b2,b1,b0}.
  - `cpu_enable` rises 30 cycles after `start`; `gpr0`/`gpr1`/memory results match the program.
- Same load with random `s_valid` gaps → identical memory contents, and no byte is duplicated or lost.
- `BIG_ENDIAN=1`, `len=1`, bytes 0x11,0x22,0x33,0x44 → `mem_wdata`=0x11223344 at address 0.
- `len=0` → no `mem_wen`, `cpu_enable=1` one cycle after `start`. `len=DEPTH+1` → `err=1`, state stays IDLE; the next valid `start` clears `err`.
- `abort` after 2 bytes of word 3 → no write to address 3, IDLE next cycle, `s_ready=0`. A following `start` with `len=2` writes addresses 0 and 1.
- `rst` asserted mid-COLLECT, between clock edges → all outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_boot_loader_if #(
  parameter int WORD_W = 32,
  parameter int BYTE_W = 8,
  parameter int ADDR_W = 10
);
  logic [BYTE_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  modport master (output s_data, s_valid, input s_ready, mem_wen, mem_addr, mem_wdata);
  modport slave  (input s_data, s_valid, output s_ready, mem_wen, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_boot_loader.sv
// Packs a byte stream into words and writes them to imem from address 0, then enables the CPU.
// Latency NB+1 cycles per word; s_ready only in COLLECT, s_valid gaps simply stall packing.
module imem_boot_loader #(
  parameter int WORD_W     = 32,
  parameter int BYTE_W     = 8,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = 10,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  imem_boot_loader_if.slave bus,
  output logic              cpu_enable,
  output logic              busy,
  output logic              err
);
  localparam int NB   = WORD_W / BYTE_W;
  localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NB-1);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, RUN} state_t;

  state_t            state, state_nxt;
  logic [BC_W-1:0]   byte_cnt, byte_cnt_nxt;
  logic [ADDR_W-1:0] word_cnt, word_cnt_nxt;
  logic [ADDR_W:0]   len_q, len_nxt;
  logic [WORD_W-1:0] pack_q, pack_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [WORD_W-1:0] wdata_q, wdata_nxt;
  logic              err_q, err_nxt;
  logic              wen_q, run_q, busy_q;
  int                lane;

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    word_cnt_nxt = word_cnt;
    len_nxt      = len_q;
    pack_nxt     = pack_q;
    addr_nxt     = addr_q;
    wdata_nxt    = wdata_q;
    err_nxt      = err_q;
    lane         = BIG_ENDIAN ? (NB - 1 - int'(byte_cnt)) : int'(byte_cnt);

    if (abort) begin
      // partial word is dropped; already written words stay in memory
      state_nxt    = IDLE;
      byte_cnt_nxt = '0;
      word_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (len > DEPTH_L) begin
              err_nxt = 1'b1;
            end else begin
              err_nxt = 1'b0;
              if (len == '0) begin
                state_nxt = RUN;
              end else begin
                len_nxt      = len;
                byte_cnt_nxt = '0;
                word_cnt_nxt = '0;
                state_nxt    = COLLECT;
              end
            end
          end
        end
        COLLECT: begin
          if (bus.s_valid) begin
            pack_nxt[lane*BYTE_W +: BYTE_W] = bus.s_data;
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt_nxt = '0;
              addr_nxt     = word_cnt;
              wdata_nxt    = pack_nxt;
              state_nxt    = WRITE;
            end else begin
              byte_cnt_nxt = byte_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          if (({1'b0, word_cnt} + (ADDR_W+1)'(1)) == len_q) begin
            state_nxt = RUN;
          end else begin
            word_cnt_nxt = word_cnt + 1'b1;
            byte_cnt_nxt = '0;
            state_nxt    = COLLECT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      word_cnt <= '0;
      len_q    <= '0;
      pack_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      wen_q    <= 1'b0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      word_cnt <= word_cnt_nxt;
      len_q    <= len_nxt;
      pack_q   <= pack_nxt;
      addr_q   <= addr_nxt;
      wdata_q  <= wdata_nxt;
      err_q    <= err_nxt;
      wen_q    <= (state_nxt == WRITE);
      run_q    <= (state_nxt == RUN);
      busy_q   <= (state_nxt == COLLECT) || (state_nxt == WRITE);
    end
  end

  assign bus.s_ready   = (state == COLLECT) && !abort;
  assign bus.mem_wen   = wen_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_enable    = run_q;
  assign busy          = busy_q;
  assign err           = err_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: cycle-level reference model plus literal checks of the key scenarios.
module tb_imem_boot_loader;
  logic        clk = 1'b0;
  logic        rst, start, abort, start_b, abort_b;
  logic [10:0] len, len_b;
  logic        cpu_enable, busy, err, cpu_enable_b, busy_b, err_b;
  int          n_chk = 0, n_err = 0, cyc = 0, t_start = 0, wen_cnt = 0;
  int          be_cnt = 0;
  logic [9:0]  be_addr;
  logic [31:0] be_data;
  bit          chk_on = 1'b0;
  logic [31:0] imem    [0:1023];
  logic [31:0] exp_mem [0:1023];

  logic [7:0]  prog_b [24] = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h30, 8'h00,
                               8'hb3, 8'h81, 8'h20, 8'h00, 8'h23, 8'h20, 8'h30, 8'h00,
                               8'h13, 8'h00, 8'h00, 8'h00, 8'h6f, 8'h00, 8'h00, 8'h00};
  logic [31:0] prog_w [6]  = '{32'h00500093, 32'h00300113, 32'h002081b3,
                               32'h00302023, 32'h00000013, 32'h0000006f};
  logic [7:0]  be_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  imem_boot_loader_if bus ();
  imem_boot_loader_if bus_b ();

  imem_boot_loader dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort), .bus(bus),
    .cpu_enable(cpu_enable), .busy(busy), .err(err));

  imem_boot_loader #(.BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst(rst), .start(start_b), .len(len_b), .abort(abort_b), .bus(bus_b),
    .cpu_enable(cpu_enable_b), .busy(busy_b), .err(err_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase of the load plus counts of accepted bytes and finished words.
  typedef enum {M_IDLE, M_LOAD, M_RUN} mphase_t;
  mphase_t     m_ph;
  bit          m_wpend, m_err;
  int          m_len, m_words, m_nbytes;
  logic [31:0] m_acc, m_data;
  logic [9:0]  m_addr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = M_IDLE; m_wpend = 0; m_err = 0; m_words = 0; m_nbytes = 0;
      m_acc = 0; m_data = 0; m_addr = 0; m_len = 0;
    end else if (abort) begin
      m_ph = M_IDLE; m_wpend = 0; m_nbytes = 0; m_acc = 0;
    end else begin
      case (m_ph)
        M_IDLE: if (start) begin
          if (int'(len) > 1024) m_err = 1;
          else begin
            m_err = 0; m_len = int'(len); m_words = 0; m_nbytes = 0; m_acc = 0;
            m_ph = (len == 0) ? M_RUN : M_LOAD;
          end
        end
        M_LOAD: if (m_wpend) begin
          m_wpend = 0;
          m_words++;
          if (m_words == m_len) m_ph = M_RUN;
        end else if (bus.s_valid) begin
          m_acc = m_acc | (32'(bus.s_data) << (8 * m_nbytes));
          m_nbytes++;
          if (m_nbytes == 4) begin
            m_wpend = 1; m_addr = 10'(m_words); m_data = m_acc;
            exp_mem[m_words] = m_acc; m_nbytes = 0; m_acc = 0;
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_on) begin
      chk("s_ready", 32'(bus.s_ready), 32'((m_ph == M_LOAD) && !m_wpend && !abort));
      chk("mem_wen", 32'(bus.mem_wen), 32'(m_wpend));
      chk("cpu_enable", 32'(cpu_enable), 32'(m_ph == M_RUN));
      chk("busy", 32'(busy), 32'(m_ph == M_LOAD));
      chk("err", 32'(err), 32'(m_err));
      if (m_wpend) begin
        chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
        chk("mem_wdata", bus.mem_wdata, m_data);
      end
    end
  end

  // Instruction memory and write-strobe bookkeeping for both loaders.
  always @(negedge clk) begin
    if (!rst && bus.mem_wen) begin
      imem[bus.mem_addr] = bus.mem_wdata;
      wen_cnt++;
    end
    if (!rst && bus_b.mem_wen) begin
      be_cnt++; be_addr = bus_b.mem_addr; be_data = bus_b.mem_wdata;
    end
  end

  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) imem[i] = 32'hDEADBEEF;
    wen_cnt = 0;
  endtask

  task automatic do_start(input logic [10:0] l);
    start = 1; len = l; t_start = cyc + 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic do_abort();
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int  n;
    bit  acc;
    n = 0; acc = 0;
    if (gaps && $urandom_range(0, 2) == 0) begin
      bus.s_valid = 0; bus.s_data = 8'($urandom);
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    bus.s_valid = 1; bus.s_data = b;
    while (!acc) begin
      @(negedge clk); acc = bus.s_ready;
      @(posedge clk); #1;
      n++;
      if (n > 50) begin chk("byte_accept_timeout", 32'(n), 32'd0); break; end
    end
  endtask

  task automatic wait_cpu(output int lat);
    int n;
    n = 0; lat = -1;
    while (n < 60) begin
      @(negedge clk);
      if (cpu_enable) begin lat = cyc - t_start; break; end
      n++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, l;
    logic [7:0] rb [8];
    rst = 1; start = 0; len = 0; abort = 0; start_b = 0; len_b = 0; abort_b = 0;
    bus.s_valid = 0; bus.s_data = 0; bus_b.s_valid = 0; bus_b.s_data = 0;
    clear_imem();
    repeat (3) @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cpu_enable", 32'(cpu_enable), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_mem_wen", 32'(bus.mem_wen), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_s_ready", 32'(bus.s_ready), 0);
    chk_on = 1;
    @(posedge clk); #1;

    // Full program, s_valid held high
    do_start(11'd6);
    for (int i = 0; i < 24; i++) send_byte(prog_b[i], 1'b0);
    bus.s_valid = 0;
    wait_cpu(lat);
    chk("cpu_enable_latency", 32'(lat), 32'd30);
    chk("word0_le", imem[0], 32'h00500093);
    for (int i = 0; i < 6; i++) chk("prog_word", imem[i], prog_w[i]);
    chk("wen_count_6", 32'(wen_cnt), 32'd6);

    // Same program with random s_valid gaps
    do_abort();
    clear_imem();
    do_start(11'd6);
    for (int i = 0; i < 24; i++) send_byte(prog_b[i], 1'b1);
    bus.s_valid = 0;
    wait_cpu(lat);
    for (int i = 0; i < 6; i++) chk("gap_prog_word", imem[i], prog_w[i]);
    chk("gap_wen_count", 32'(wen_cnt), 32'd6);

    // len == 0
    do_abort();
    clear_imem();
    do_start(11'd0);
    @(negedge clk);
    chk("len0_cpu_enable", 32'(cpu_enable), 1);
    @(posedge clk); #1;
    chk("len0_no_wen", 32'(wen_cnt), 0);

    // len > DEPTH rejected, next valid start clears err
    do_abort();
    do_start(11'd1025);
    @(negedge clk);
    chk("oversize_err", 32'(err), 1);
    chk("oversize_idle", 32'(busy | cpu_enable), 0);
    @(posedge clk); #1;
    do_start(11'd0);
    @(negedge clk);
    chk("err_cleared", 32'(err), 0);
    @(posedge clk); #1;

    // Abort after two bytes of word 3
    do_abort();
    clear_imem();
    do_start(11'd6);
    for (int i = 0; i < 14; i++) send_byte(prog_b[i], 1'b0);
    abort = 1; bus.s_data = prog_b[14];
    @(negedge clk);
    chk("abort_s_ready", 32'(bus.s_ready), 0);
    @(posedge clk); #1;
    abort = 0;
    @(negedge clk);
    chk("abort_idle_busy", 32'(busy), 0);
    chk("abort_idle_s_ready", 32'(bus.s_ready), 0);
    chk("abort_no_addr3", imem[3], 32'hDEADBEEF);
    chk("abort_wen_count", 32'(wen_cnt), 32'd3);
    @(posedge clk); #1;
    bus.s_valid = 0;
    do_start(11'd2);
    for (int i = 0; i < 8; i++) begin rb[i] = 8'($urandom); send_byte(rb[i], 1'b1); end
    bus.s_valid = 0;
    wait_cpu(lat);
    chk("reload_word0", imem[0], {rb[3], rb[2], rb[1], rb[0]});
    chk("reload_word1", imem[1], {rb[7], rb[6], rb[5], rb[4]});
    chk("reload_wen_count", 32'(wen_cnt), 32'd5);

    // Randomized loads against the model's memory image
    for (int r = 0; r < 3; r++) begin
      do_abort();
      clear_imem();
      l = $urandom_range(1, 8);
      do_start(11'(l));
      for (int i = 0; i < 4 * l; i++) send_byte(8'($urandom), 1'b1);
      bus.s_valid = 0;
      wait_cpu(lat);
      for (int i = 0; i < l; i++) chk("rand_word", imem[i], exp_mem[i]);
      chk("rand_wen_count", 32'(wen_cnt), 32'(l));
    end

    // Big-endian packing on the second loader
    start_b = 1; len_b = 11'd1;
    @(posedge clk); #1;
    start_b = 0;
    bus_b.s_valid = 1;
    for (int i = 0; i < 4; i++) begin bus_b.s_data = be_bytes[i]; @(posedge clk); #1; end
    bus_b.s_valid = 0;
    @(posedge clk); #1;
    chk("be_wen_count", 32'(be_cnt), 1);
    chk("be_addr", 32'(be_addr), 0);
    chk("be_wdata", be_data, 32'h11223344);
    chk("be_cpu_enable", 32'(cpu_enable_b), 1);

    // Asynchronous reset mid-COLLECT
    do_abort();
    do_start(11'd2);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    #1 rst = 1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_s_ready", 32'(bus.s_ready), 0);
    chk("arst_cpu_enable", 32'(cpu_enable), 0);
    chk("arst_mem_wen", 32'(bus.mem_wen), 0);
    chk("arst_mem_addr", 32'(bus.mem_addr), 0);
    chk("arst_mem_wdata", bus.mem_wdata, 0);
    chk("arst_err", 32'(err), 0);
    chk("arst_be_cpu_enable", 32'(cpu_enable_b), 0);
    bus.s_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "timeout");
  end
endmodule
